// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage that feeds the IF/ID instruction register from a combinational 128x16 IRAM
// Ports:
//   CLK        in   1  system clock, rising edge
//   RESET      in   1  asynchronous active-high reset
//   STALL      in   1  hold request from decode/hazard logic
//   BR_TAKEN   in   1  redirect request for the instruction in IR
//   BR_TARGET  in   8  redirect byte address (bit 0 ignored)
//   IRAM_ADDR  out  8  byte address to IRAM (the PC)
//   IRAM_DATA  in  16  word returned by IRAM in the same cycle
//   IR         out 16  latched instruction
//   IR_PC      out  8  byte address IR was fetched from
//   PC_PLUS2   out  8  IR_PC + 2, modulo 256
//   IR_VALID   out  1  IR holds a live instruction
//   HALTED     out  1  fetch is halted on an all-zero word
//   FETCH_CNT  out 16  saturating count of valid words loaded into IR
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter bit         HALT_ON_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [7:0]  BR_TARGET,
    output logic [7:0]  IRAM_ADDR,
    input  logic [15:0] IRAM_DATA,
    output logic [15:0] IR,
    output logic [7:0]  IR_PC,
    output logic [7:0]  PC_PLUS2,
    output logic        IR_VALID,
    output logic        HALTED,
    output logic [15:0] FETCH_CNT
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state, state_n;
    logic [7:0]  pc, pc_n, ir_pc_n;
    logic [15:0] ir_n, cnt_n;
    logic        valid_n;

    assign IRAM_ADDR = pc;
    assign PC_PLUS2  = IR_PC + 8'd2;
    assign HALTED    = (state == HALT);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = IR;
        ir_pc_n = IR_PC;
        valid_n = IR_VALID;
        cnt_n   = FETCH_CNT;
        case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (BR_TAKEN) begin
                    pc_n    = BR_TARGET & 8'hFE;
                    valid_n = 1'b0;
                end else if (!STALL) begin
                    if (HALT_ON_ZERO && IRAM_DATA == 16'h0000) begin
                        valid_n = 1'b0;
                        state_n = HALT;
                    end else begin
                        ir_n    = IRAM_DATA;
                        ir_pc_n = pc;
                        valid_n = 1'b1;
                        pc_n    = pc + 8'd2;
                        cnt_n   = FETCH_CNT + {15'd0, ~&FETCH_CNT};
                    end
                end
            end
            HALT: begin
                valid_n = 1'b0;
                if (BR_TAKEN) begin
                    pc_n    = BR_TARGET & 8'hFE;
                    state_n = RUN;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= BOOT;
            pc        <= RESET_PC & 8'hFE;
            IR        <= 16'h0000;
            IR_PC     <= 8'h00;
            IR_VALID  <= 1'b0;
            FETCH_CNT <= 16'h0000;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            IR        <= ir_n;
            IR_PC     <= ir_pc_n;
            IR_VALID  <= valid_n;
            FETCH_CNT <= cnt_n;
        end
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the 128x16 instruction RAM (byte-addressed, ADDR[7:1] word select, combinational read).
- Holds the 8-bit PC, drives the IRAM address, and latches the returned word into an instruction register (IF/ID latch) with a valid bit for the decoder.
- Supports stall, taken-branch redirect with flush, a post-reset boot bubble, halt on an all-zero word (unprogrammed IRAM is zero-filled), and a fetch counter.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset; bit 0 ignored (forced to 0).
- HALT_ON_ZERO, 1, 1 = a fetched 16'h0000 halts fetch; 0 = 16'h0000 is an ordinary instruction.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- STALL  in  1  hold request from decode/hazard logic.
- BR_TAKEN  in  1  redirect request for the instruction currently in IR.
- BR_TARGET  in  8  redirect byte address.
- IRAM_ADDR  out  8  byte address to IRAM; equals PC combinationally.
- IRAM_DATA  in  16  instruction word returned by IRAM (same cycle).
- IR  out  16  latched instruction.
- IR_PC  out  8  byte address IR was fetched from.
- PC_PLUS2  out  8  IR_PC + 2, modulo 256 (branch/link base).
- IR_VALID  out  1  IR holds a live instruction.
- HALTED  out  1  fetch is in HALT state.
- FETCH_CNT  out  16  count of words loaded into IR with IR_VALID=1, saturating.

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC & 8'hFE; IR = 0; IR_PC = 0; IR_VALID = 0; FETCH_CNT = 0; state = BOOT; HALTED = 0.
  - PC_PLUS2 = 8'h02 during reset.
- States: BOOT, RUN, HALT. HALTED = (state == HALT). Update priority each edge: RESET > BR_TAKEN > STALL > normal.
- BOOT: exactly one edge after RESET falls with no fetch; IR_VALID stays 0; PC holds; go to RUN. BR_TAKEN and STALL are ignored in BOOT. This gives IRAM, which is loaded synchronously while RESET is high, a settled cycle.
- RUN, BR_TAKEN=1 (regardless of STALL):
  - PC <= BR_TARGET & 8'hFE.
  - IR_VALID <= 0, so the wrong-path word is flushed and not counted.
  - IR and IR_PC hold; stay RUN.
- RUN, STALL=1, no branch: PC, IR, IR_PC, IR_VALID, FETCH_CNT all hold.
- RUN, normal, IRAM_DATA != 0 or HALT_ON_ZERO=0:
  - IR <= IRAM_DATA; IR_PC <= PC; IR_VALID <= 1.
  - PC <= PC + 2, wrapping 8'hFE -> 8'h00.
  - FETCH_CNT <= FETCH_CNT + 1, saturating at 16'hFFFF.
- RUN, normal, IRAM_DATA == 0 and HALT_ON_ZERO=1:
  - IR_VALID <= 0; PC holds (points at the zero word); FETCH_CNT holds.
  - Go to HALT.
- HALT:
  - All registers hold; IR_VALID = 0.
  - BR_TAKEN=1 sets PC <= BR_TARGET & 8'hFE and returns to RUN. This covers a branch from an older in-flight instruction. STALL is ignored.
  - Otherwise leave HALT only by RESET.
- Latency:
  - Word at PC appears on IR one edge after PC is presented with STALL=0.
  - Branch redirect costs one bubble: IR_VALID is low for one cycle after the redirect edge.
- Reset mid-operation: asserting RESET at any time immediately forces reset values. This includes during STALL, HALT, or the same cycle as BR_TAKEN.
- No combinational path from IRAM_DATA to any output; IRAM_ADDR depends only on PC.

Test Plan:
- Reset then run, IRAM words 0..3 = 16'hF001, 16'h517F, 16'h2A7A, 16'h2ABB, STALL=0:
  - After the BOOT edge, IRAM_ADDR = 00, 02, 04, 06 on successive cycles.
  - IR follows one cycle later with IR_PC = 00, 02, 04.
  - FETCH_CNT = 1, 2, 3; PC_PLUS2 = 02, 04, 06.
- STALL held 3 cycles with IR=16'h2A7A, IR_PC=04:
  - IR, IR_PC, IR_VALID=1, PC=06 and FETCH_CNT all unchanged.
  - Fetch resumes at 06 on release.
- BR_TAKEN=1, BR_TARGET=8'h15 while STALL=1:
  - Next cycle IRAM_ADDR = 8'h14 and IR_VALID = 0.
  - The following cycle IR = mem[10] with IR_PC = 14.
- Halt with mem[32] = 0 and HALT_ON_ZERO=1, run to PC=8'h40:
  - HALTED = 1, IR_VALID = 0, PC = 8'h40, FETCH_CNT = 32, held for 10 cycles.
  - Then BR_TAKEN with BR_TARGET=8'h00: HALTED = 0 and fetch restarts at 00.
- Wrap and parameter:
  - HALT_ON_ZERO=0, RESET_PC=8'hFE: fetches FE then 00; IR = 16'h0000 is valid and counted.
  - RESET asserted mid-run asynchronously (between edges): outputs take reset values immediately; BOOT bubble is seen after release.
